// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car and the upstream direction
// controller: command encodings, car FSM states and floor defaults.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 8;
    localparam int DEF_FLOOR_W    = 4;

    // Direction command encodings; 2'b01 is reserved and decodes as WAIT.
    localparam logic [1:0] CMD_WAIT = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } car_state_e;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door timing. A load takes
// priority; otherwise the count decrements and saturates at zero.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i this cycle
//   load_val_i   value to load
//   value_o      current count
//   zero_o       count is zero
module elevator_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/elevator_car.sv
// Car motion and door sequencer. Follows the direction controller's
// command, moves one floor per TRAVEL_CYCLES, opens the door for
// DOOR_CYCLES at requested floors and pulses a one-hot clear back to the
// request latch.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cmd           direction command (WAIT=00, UP=10, DOWN=11, 01=WAIT)
//   fr            latched floor requests, bit i = floor i
//   cur_floor     registered car position
//   door_opened   registered, high while the door is open
//   clr           registered one-cycle one-hot clear of the request at cur_floor
//   motion        registered current action, cmd encoding
module elevator_car
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cmd,
    input  logic [NUM_FLOORS-1:0] fr,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  door_opened,
    output logic [NUM_FLOORS-1:0] clr,
    output logic [1:0]            motion
);

    car_state_e            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  door_q, door_d;
    logic [NUM_FLOORS-1:0] clr_q, clr_d;
    logic [1:0]            motion_q, motion_d;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_load_val;
    logic [CNT_W-1:0]      tmr_value;
    logic                  tmr_zero;

    logic [NUM_FLOORS-1:0] here_mask;
    logic                  req_here;
    logic                  at_top;
    logic                  at_bottom;

    assign here_mask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_q;
    assign req_here  = |(fr & here_mask);
    assign at_top    = (floor_q == FLOOR_W'(NUM_FLOORS - 1));
    assign at_bottom = (floor_q == '0);

    elevator_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        door_d       = door_q;
        clr_d        = '0;
        motion_d     = motion_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d      = DOOR_OPEN;
                    door_d       = 1'b1;
                    clr_d        = here_mask;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(DOOR_CYCLES - 1);
                end else if (cmd == CMD_UP && !at_top) begin
                    state_d      = MOVE_UP;
                    motion_d     = CMD_UP;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(TRAVEL_CYCLES - 1);
                end else if (cmd == CMD_DOWN && !at_bottom) begin
                    state_d      = MOVE_DOWN;
                    motion_d     = CMD_DOWN;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(TRAVEL_CYCLES - 1);
                end
            end
            MOVE_UP: begin
                if (tmr_zero) begin
                    floor_d  = floor_q + 1'b1;
                    motion_d = CMD_WAIT;
                    state_d  = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (tmr_zero) begin
                    floor_d  = floor_q - 1'b1;
                    motion_d = CMD_WAIT;
                    state_d  = IDLE;
                end
            end
            DOOR_OPEN: begin
                // While clr is high the latch still shows the request being
                // cleared; only a press seen with clr low is a fresh one.
                if (req_here && clr_q == '0) begin
                    clr_d        = here_mask;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(DOOR_CYCLES - 1);
                end else if (tmr_zero) begin
                    door_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            door_q   <= 1'b0;
            clr_q    <= '0;
            motion_q <= CMD_WAIT;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            door_q   <= door_d;
            clr_q    <= clr_d;
            motion_q <= motion_d;
        end
    end

    assign cur_floor   = floor_q;
    assign door_opened = door_q;
    assign clr         = clr_q;
    assign motion      = motion_q;

    // Every operation ends on an expired timer, so IDLE always sees zero.
    a_idle_timer_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> (tmr_value == '0));
    a_door_no_motion: assert property (@(posedge clk) disable iff (!rst_n)
        door_q |-> (motion_q == CMD_WAIT));

endmodule
